keccak_iota_stream: RTL

- Parametrised, registered iota step for Keccak-f[25·2^L] with a built-in round-constant LFSR and round counter.
- Each accepted state beat is XORed with the current round's constant; the round index then advances and wraps after NR rounds.
- Sits between the chi stage and the next round's theta in the iterative permutation core (SHA3-256 uses the L=6, NR=24 build).
- Valid/ready streaming on both sides, with one output register stage.

---
 rtl/keccak_iota_stream_if.sv | 31 +++
 rtl/keccak_iota_stream.sv | 114 +++++++++++
 2 files changed

// File: rtl/keccak_iota_stream_if.sv
// Stream bundle around the Keccak iota stage: an input state beat and the
// registered iota result with its round tags.
interface keccak_iota_stream_if #(
  parameter int L = 6
);
  localparam int W  = 1 << L;
  localparam int SW = 25 * W;

  // Both sides are valid/ready: a beat moves on a rising edge where valid and
  // ready are both high; valid never waits for ready, and a held beat keeps
  // its payload stable until it moves.
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_state;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_state;
  logic [L:0]    out_rc;
  logic [4:0]    out_round;
  logic          out_last;

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, out_rc, out_round, out_last
  );

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, out_rc, out_round, out_last
  );
endinterface

// File: rtl/keccak_iota_stream.sv
// Registered Keccak iota step with its own round counter and rc(t) LFSR;
// one output register stage, full throughput under valid/ready.
module keccak_iota_stream #(
  parameter int L  = 6,
  parameter int NR = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  keccak_iota_stream_if.slave io
);
  localparam int W     = 1 << L;
  localparam int SW    = 25 * W;
  localparam int IR0   = 12 + 2 * L - NR;
  localparam int ILAST = IR0 + NR - 1;

  // One rc(t) step for x^8+x^6+x^5+x^4+1; bit 0 of the state is rc(t).
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
  endfunction

  function automatic logic [7:0] lfsr_adv(input int n);
    logic [7:0] s;
    s = 8'h01;
    for (int i = 0; i < n; i++) s = lfsr_step(s);
    return s;
  endfunction

  localparam logic [7:0] SEED   = lfsr_adv(7 * IR0);
  localparam logic [4:0] IR0_V  = 5'(IR0);
  localparam logic [4:0] LAST_V = 5'(ILAST);

  logic [4:0]    round_q, round_d, cur_round;
  logic [7:0]    lfsr_q, lfsr_d, cur_lfsr;
  logic [7:0]    chain [0:7];
  logic [L:0]    rc;
  logic [SW-1:0] iota_mask;
  logic          is_last;
  logic          accept;

  logic          valid_q, valid_d;
  logic [SW-1:0] state_q, state_d;
  logic [L:0]    rc_q, rc_d;
  logic [4:0]    oround_q, oround_d;
  logic          last_q, last_d;

  assign io.in_ready  = !valid_q || io.out_ready;
  assign accept       = io.in_valid && io.in_ready;
  assign io.out_valid = valid_q;
  assign io.out_state = state_q;
  assign io.out_rc    = rc_q;
  assign io.out_round = oround_q;
  assign io.out_last  = last_q;

  // clr in the same cycle as an accept makes that beat round IR0.
  always_comb begin
    cur_round = clr ? IR0_V : round_q;
    cur_lfsr  = clr ? SEED : lfsr_q;
    chain[0]  = cur_lfsr;
    for (int k = 0; k < 7; k++) chain[k+1] = lfsr_step(chain[k]);
    rc        = '0;
    iota_mask = '0;
    for (int j = 0; j <= L; j++) begin
      rc[j]                    = chain[j][0];
      iota_mask[(1 << j) - 1]  = chain[j][0];
    end
    is_last = (cur_round == LAST_V);
  end

  always_comb begin
    round_d  = round_q;
    lfsr_d   = lfsr_q;
    valid_d  = valid_q;
    state_d  = state_q;
    rc_d     = rc_q;
    oround_d = oround_q;
    last_d   = last_q;
    if (clr) begin
      round_d = IR0_V;
      lfsr_d  = SEED;
    end
    if (accept) begin
      round_d  = is_last ? IR0_V : cur_round + 5'd1;
      lfsr_d   = is_last ? SEED : chain[7];
      valid_d  = 1'b1;
      state_d  = io.in_state ^ iota_mask;
      rc_d     = rc;
      oround_d = cur_round;
      last_d   = is_last;
    end else if (io.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q  <= IR0_V;
      lfsr_q   <= SEED;
      valid_q  <= 1'b0;
      state_q  <= '0;
      rc_q     <= '0;
      oround_q <= '0;
      last_q   <= 1'b0;
    end else begin
      round_q  <= round_d;
      lfsr_q   <= lfsr_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
      rc_q     <= rc_d;
      oround_q <= oround_d;
      last_q   <= last_d;
    end
  end
endmodule
